// File: rtl/ddr_wr_req_gen.sv
// ddr_wr_req_gen
// Splits a 256-bit source stream into paired BL8 write bursts: two data
// beats into the write-data FIFO and one burst address into the
// write-address FIFO. The address is pushed with the second beat of each
// burst, so it never precedes its data. Addresses walk a circular region
// [ADDR_BASE, ADDR_BASE + ADDR_SPAN).
//
// Optional feature macro: DDR_WR_PAD_EN
//   defined     - a frame whose s_last lands on the first beat of a burst is
//                 completed with a zero pad beat, and its address is pushed
//                 immediately.
//   not defined - s_last is ignored, S_PAD is unreachable, pad_cnt reads 0.
module ddr_wr_req_gen #(
    parameter logic [28:0] ADDR_BASE = 29'h0,
    parameter logic [28:0] ADDR_SPAN = 29'h0100_0000,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [255:0] s_data,
    input  logic         s_last,
    input  logic         restart,
    output logic         wdata_fifo_wr_en,
    output logic [255:0] wdata_fifo_din,
    input  logic         wdata_fifo_full,
    output logic         waddr_fifo_wr_en,
    output logic [29:0]  waddr_fifo_din,
    input  logic         waddr_fifo_full,
    output logic [28:0]  wr_ptr,
    output logic [31:0]  burst_cnt,
    output logic [15:0]  pad_cnt
);

    // Pointer arithmetic is done one bit wider so the region end cannot overflow.
    localparam logic [29:0] STEP_W   = 30'(ADDR_STEP);
    localparam logic [29:0] ADDR_END = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};

    typedef enum logic [1:0] {
        S_EVEN = 2'd0,
        S_ODD  = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        fifo_room;
    logic        beat_acc;
    logic        pad_push;
    logic        addr_push;
    logic        restart_pend;
    logic [29:0] ptr_sum;
    logic [28:0] ptr_adv;

    // Both FIFOs must have room, so a burst can never be split by a stall.
    assign fifo_room = !wdata_fifo_full && !waddr_fifo_full;

    // Source handshake and push qualifiers; everything is held off in reset.
    always_comb begin
        s_ready  = rst_n && fifo_room && (state != S_PAD);
        beat_acc = s_valid && s_ready;
`ifdef DDR_WR_PAD_EN
        pad_push = rst_n && fifo_room && (state == S_PAD);
`else
        pad_push = 1'b0;
`endif
        addr_push = (beat_acc && (state == S_ODD)) || pad_push;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_EVEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: beat parity tracking plus the optional pad detour.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EVEN: begin
                if (beat_acc) begin
                    state_nxt = S_ODD;
`ifdef DDR_WR_PAD_EN
                    if (s_last) begin
                        state_nxt = S_PAD;
                    end
`endif
                end
            end
            S_ODD: begin
                if (beat_acc) begin
                    state_nxt = S_EVEN;
                end
            end
            S_PAD: begin
                if (pad_push) begin
                    state_nxt = S_EVEN;
                end
            end
            default: state_nxt = S_EVEN;
        endcase
    end

    // FIFO push outputs: zero-latency pass-through of the accepted beat.
    always_comb begin
        wdata_fifo_wr_en = beat_acc || pad_push;
        wdata_fifo_din   = pad_push ? 256'b0 : s_data;
        waddr_fifo_wr_en = addr_push;
        waddr_fifo_din   = {1'b0, wr_ptr};
    end

    // Next linear burst address, wrapping back to the region base.
    always_comb begin
        ptr_sum = {1'b0, wr_ptr} + STEP_W;
        ptr_adv = (ptr_sum >= ADDR_END) ? ADDR_BASE : ptr_sum[28:0];
    end

    // Address pointer and restart handling; a restart mid-burst is deferred
    // until the burst's address has been pushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= ADDR_BASE;
            restart_pend <= 1'b0;
        end else if (addr_push) begin
            wr_ptr       <= (restart || restart_pend) ? ADDR_BASE : ptr_adv;
            restart_pend <= 1'b0;
        end else if (restart) begin
            if (state == S_EVEN) begin
                wr_ptr <= ADDR_BASE;
            end else begin
                restart_pend <= 1'b1;
            end
        end
    end

    // Completed-burst counter, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt <= 32'd0;
        end else if (addr_push) begin
            burst_cnt <= burst_cnt + 32'd1;
        end
    end

`ifdef DDR_WR_PAD_EN
    // Pad beat counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_cnt <= 16'd0;
        end else if (pad_push && (pad_cnt != 16'hFFFF)) begin
            pad_cnt <= pad_cnt + 16'd1;
        end
    end
`else
    logic unused_s_last;

    assign unused_s_last = s_last;
    assign pad_cnt       = 16'd0;
`endif

endmodule

// File: doc/ddr_wr_req_gen.md
# ddr_wr_req_gen

Upstream write-request generator for the DDR application arbiter. It accepts a 256-bit streaming source and splits it into two paired FIFO streams: two data beats per BL8 burst into the write-data FIFO, and one 30-bit burst address into the write-address FIFO. Addresses step linearly through a circular DDR region. The arbiter downstream pops one address per two data beats, so this block guarantees that the data and address streams stay paired.

## Interface
Parameters:
- ADDR_BASE, 29'h0, first burst address of the circular region (must be a multiple of 8).
- ADDR_SPAN, 29'h0100_0000, region size in address units (must be a multiple of 8 and ≥ 8).
- ADDR_STEP, 8, address increment per burst (BL8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  source beat valid.
- s_ready  out  1  source beat accepted when s_valid & s_ready.
- s_data  in  256  source beat payload.
- s_last  in  1  marks the final beat of a frame (qualified by s_valid).
- restart  in  1  single-cycle pulse; returns the address pointer to ADDR_BASE.
- wdata_fifo_wr_en  out  1  write-data FIFO push.
- wdata_fifo_din  out  256  write-data FIFO payload.
- wdata_fifo_full  in  1  write-data FIFO full.
- waddr_fifo_wr_en  out  1  write-address FIFO push.
- waddr_fifo_din  out  30  {1'b0, burst address[28:0]}.
- waddr_fifo_full  in  1  write-address FIFO full.
- wr_ptr  out  29  address of the next burst to be issued.
- burst_cnt  out  32  number of completed bursts; wraps modulo 2^32.
- pad_cnt  out  16  number of pad beats inserted; saturates at 16'hFFFF.

## Operation
State machine with three states:
- S_EVEN: expecting the first beat of a burst. On an accepted beat, go to S_ODD. If that beat has s_last set and DDR_WR_PAD_EN is defined, go to S_PAD instead.
- S_ODD: expecting the second beat. On an accepted beat, push the address and go to S_EVEN.
- S_PAD: s_ready = 0. When both FIFOs are not full, push a zero data beat and the address, increment pad_cnt, and go to S_EVEN.

Handshake and pushes:
- s_ready = !wdata_fifo_full & !waddr_fifo_full & (state != S_PAD), evaluated in every state. Both flags are checked so that a burst is never split by a stall.
- wdata_fifo_wr_en = (s_valid & s_ready) | pad push. wdata_fifo_din = s_data, or 256'b0 on a pad push.
- waddr_fifo_wr_en asserts only when the second beat of a burst is pushed (real or pad). The address therefore never precedes its data.

Address and counters:
- waddr_fifo_din = {1'b0, wr_ptr}.
- On each address push, wr_ptr advances: next = wr_ptr + ADDR_STEP, computed at 30 bits. If next ≥ ADDR_BASE + ADDR_SPAN, next = ADDR_BASE (wrap-around).
- burst_cnt increments by 1 on each address push.

Restart:
- In S_EVEN, restart loads ADDR_BASE into wr_ptr on the next edge.
- In S_ODD or S_PAD, restart is latched as pending. It is applied in place of the normal advance when the burst completes.
- If restart coincides with a completing push, the reload wins and wr_ptr = ADDR_BASE.

Other rules:
- s_last on the second beat needs no special action.
- s_data is don't-care when s_valid = 0.

## Timing
- Fully combinational push path: accepted beat → FIFO write enables in the same cycle, zero latency.
- wr_ptr, burst_cnt, pad_cnt and the restart-pending flag update on the edge after the push.
- Reset values:
  - state = S_EVEN, wr_ptr = ADDR_BASE, burst_cnt = 0, pad_cnt = 0, restart pending = 0.
  - All write enables = 0 and s_ready = 0 while rst_n = 0.
- Reset during S_ODD discards the half burst: nothing is pushed, and the address FIFO stays consistent with the data FIFO only if the FIFOs are reset together. The system resets both.
- A pad push occurs in the first cycle after entry to S_PAD in which both FIFOs are not full. Pad entry therefore adds ≥ 1 cycle of s_ready = 0.

## Configuration
- DDR_WR_PAD_EN defined: an odd-length frame (s_last on the first beat) is completed with a zero pad beat and its address is pushed immediately.
- DDR_WR_PAD_EN not defined: s_last is ignored, S_PAD is unreachable, and pad_cnt is tied to 0. An odd trailing beat stays pending until the next frame's first beat completes the burst.

## Test plan
- Back-to-back stream of 4 beats, ADDR_BASE = 0 → 4 data pushes; addresses 0x0 then 0x8, pushed on beats 2 and 4; burst_cnt = 2; wr_ptr = 0x10.
- ADDR_SPAN = 16, 6 beats → addresses 0x0, 0x8, 0x0 (wrap); wr_ptr ends at 0x8.
- wdata_fifo_full held high for 5 cycles during S_ODD → s_ready = 0, no pushes; on release, the second beat pushes data and address in the same cycle.
- DDR_WR_PAD_EN defined, 3-beat frame with s_last on beat 3 → 4th data push = 256'b0, addresses 0x0 and 0x8, pad_cnt = 1. Without the macro → only 3 data pushes and 1 address push.
- restart pulsed in S_ODD at wr_ptr = 0x40 → the burst completes with address 0x40, then wr_ptr = ADDR_BASE; restart in S_EVEN → wr_ptr = ADDR_BASE on the next edge.
- rst_n low mid-burst (S_ODD) → state = S_EVEN, wr_ptr = ADDR_BASE, counters 0, no address push for the half burst.
